// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I opcode, funct7 and ALU control constants
package rv32i_pkg;

    // Major opcodes handled by this decode stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // funct7 encodings: base form and the alternate (sub/sra/srai) form
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU control codes, shared with the execute-stage ALU
    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_SLL   = 5'b00010;
    localparam logic [4:0] ALU_SLT   = 5'b00011;
    localparam logic [4:0] ALU_SLTU  = 5'b00100;
    localparam logic [4:0] ALU_XOR   = 5'b00101;
    localparam logic [4:0] ALU_SRL   = 5'b00110;
    localparam logic [4:0] ALU_SRA   = 5'b00111;
    localparam logic [4:0] ALU_OR    = 5'b01000;
    localparam logic [4:0] ALU_AND   = 5'b01001;
    localparam logic [4:0] ALU_ADDI  = 5'b01010;
    localparam logic [4:0] ALU_SLTI  = 5'b01011;
    localparam logic [4:0] ALU_SLTIU = 5'b01100;
    localparam logic [4:0] ALU_XORI  = 5'b01101;
    localparam logic [4:0] ALU_ORI   = 5'b01110;
    localparam logic [4:0] ALU_ANDI  = 5'b01111;
    localparam logic [4:0] ALU_SLLI  = 5'b10001;
    localparam logic [4:0] ALU_SRLI  = 5'b10010;
    localparam logic [4:0] ALU_SRAI  = 5'b10011;

    // One decoded instruction, as held in the pipeline register
    typedef struct packed {
        logic [4:0]  alu_ctr;
        logic        use_imm;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        reg_write;
        logic        illegal;
    } dec_t;

    // Sign-extend the 12-bit I-type immediate
    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// rtl/rv32i_decoder.sv - combinational RV32I OP/OP-IMM/LUI field decoder
module rv32i_decoder
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    // Decode: start from an illegal entry and promote it when the encoding is recognised
    always_comb begin
        dec           = '0;
        dec.rd_addr   = instr[11:7];
        dec.rs1_addr  = instr[19:15];
        dec.rs2_addr  = instr[24:20];
        dec.illegal   = 1'b1;

        unique case (opcode)
            OPC_OP: begin
                dec.illegal = 1'b0;
                case ({f7, f3})
                    {F7_BASE, 3'b000}: dec.alu_ctr = ALU_ADD;
                    {F7_ALT,  3'b000}: dec.alu_ctr = ALU_SUB;
                    {F7_BASE, 3'b001}: dec.alu_ctr = ALU_SLL;
                    {F7_BASE, 3'b010}: dec.alu_ctr = ALU_SLT;
                    {F7_BASE, 3'b011}: dec.alu_ctr = ALU_SLTU;
                    {F7_BASE, 3'b100}: dec.alu_ctr = ALU_XOR;
                    {F7_BASE, 3'b101}: dec.alu_ctr = ALU_SRL;
                    {F7_ALT,  3'b101}: dec.alu_ctr = ALU_SRA;
                    {F7_BASE, 3'b110}: dec.alu_ctr = ALU_OR;
                    {F7_BASE, 3'b111}: dec.alu_ctr = ALU_AND;
                    default:           dec.illegal = 1'b1;
                endcase
                dec.reg_write = !dec.illegal;
            end

            OPC_OP_IMM: begin
                dec.illegal = 1'b0;
                case (f3)
                    3'b000: dec.alu_ctr = ALU_ADDI;
                    3'b010: dec.alu_ctr = ALU_SLTI;
                    3'b011: dec.alu_ctr = ALU_SLTIU;
                    3'b100: dec.alu_ctr = ALU_XORI;
                    3'b110: dec.alu_ctr = ALU_ORI;
                    3'b111: dec.alu_ctr = ALU_ANDI;
                    3'b001: begin
                        if (f7 == F7_BASE) dec.alu_ctr = ALU_SLLI;
                        else               dec.illegal = 1'b1;
                    end
                    default: begin
                        // f3 = 101: funct7 selects logical vs arithmetic shift
                        if (f7 == F7_BASE)     dec.alu_ctr = ALU_SRLI;
                        else if (f7 == F7_ALT) dec.alu_ctr = ALU_SRAI;
                        else                   dec.illegal = 1'b1;
                    end
                endcase
                if (!dec.illegal) begin
                    dec.use_imm   = 1'b1;
                    dec.reg_write = 1'b1;
                    // shamt lands in imm[4:0] because it occupies instr[24:20]
                    dec.imm       = sext12(instr[31:20]);
                end
            end

            OPC_LUI: begin
                dec.illegal   = 1'b0;
                dec.alu_ctr   = ALU_ADD;
                dec.use_imm   = 1'b1;
                dec.reg_write = 1'b1;
                dec.rs1_addr  = 5'd0;
                dec.imm       = {instr[31:12], 12'b0};
            end

            default: begin
                dec.illegal = 1'b1;
            end
        endcase

        // Malformed encodings must not leave a stray ALU code behind
        if (dec.illegal) begin
            dec.alu_ctr   = ALU_ADD;
            dec.reg_write = 1'b0;
            dec.use_imm   = 1'b0;
            dec.imm       = '0;
        end
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// rtl/rv32i_decode_stage.sv - registered decode stage with handshake, flush and counter
module rv32i_decode_stage
    import rv32i_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        alu_ctr,
    output logic              use_imm,
    output logic [31:0]       imm,
    output logic [4:0]        rs1_addr,
    output logic [4:0]        rs2_addr,
    output logic [4:0]        rd_addr,
    output logic              reg_write,
    output logic              illegal,
    output logic [CNT_W-1:0]  dec_count
);

    dec_t dec_next;
    dec_t entry;
    logic accept;
    logic deliver;

    rv32i_decoder u_decoder (
        .instr (in_instr),
        .dec   (dec_next)
    );

    // The single entry can be refilled in the same cycle it is consumed
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign deliver  = out_valid && out_ready && !flush;

    // Pipeline register: flush beats both acceptance and consumption
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            entry     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            entry     <= dec_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Count entries handed to execute; wraps naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_count <= '0;
        end else if (deliver) begin
            dec_count <= dec_count + CNT_W'(1);
        end
    end

    assign alu_ctr   = entry.alu_ctr;
    assign use_imm   = entry.use_imm;
    assign imm       = entry.imm;
    assign rs1_addr  = entry.rs1_addr;
    assign rs2_addr  = entry.rs2_addr;
    assign rd_addr   = entry.rd_addr;
    assign reg_write = entry.reg_write;
    assign illegal   = entry.illegal;

endmodule

// File: doc/rv32i_decode_stage.md
Name: rv32i_decode_stage

Overview:
- Registered RV32I decode stage sitting between fetch and the ALU/execute stage.
- Accepts one 32-bit instruction per valid/ready handshake and decodes OP, OP-IMM and LUI.
- Produces the 5-bit ALU control code, register addresses, the sign-extended immediate and operand-select/write-enable flags.
- Holds the result in a one-entry pipeline register with backpressure, flush and a decoded-instruction counter.

Parameters:
- CNT_W, 32, width of the decoded-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept an instruction this cycle
- in_instr  in  32  raw instruction word
- flush  in  1  discard the held entry and any instruction offered this cycle
- out_valid  out  1  decoded entry is held
- out_ready  in  1  execute consumes the entry this cycle
- alu_ctr  out  5  ALU control code
- use_imm  out  1  operand B = imm (1) or rs2 data (0)
- imm  out  32  sign-extended immediate
- rs1_addr  out  5  source register 1
- rs2_addr  out  5  source register 2
- rd_addr  out  5  destination register
- reg_write  out  1  write rd
- illegal  out  1  unsupported or malformed instruction
- dec_count  out  CNT_W  entries delivered since reset

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid, alu_ctr, use_imm, imm, all addresses, reg_write, illegal and dec_count are all 0.
  - Reset mid-handshake drops the entry.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready && !flush. The decode is registered, so outputs are valid the cycle after acceptance (latency 1).
  - Back-to-back acceptance gives a full-throughput, no-bubble stream.
  - While out_valid && !out_ready, all outputs hold stable.
- Flush:
  - Next cycle out_valid=0; no acceptance that cycle.
  - Flush has priority over a simultaneous out_ready/in_valid.
  - dec_count does not increment on a flushed entry.
- dec_count:
  - Increments by 1 on out_valid && out_ready && !flush.
  - Wraps modulo 2^CNT_W.
- Decode (opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]):
  - OP 0110011, use_imm=0, reg_write=1. Mapping of {f7,f3} to alu_ctr:
    - 0000000/000 add 00000
    - 0100000/000 sub 00001
    - 0000000/001 sll 00010
    - 0000000/010 slt 00011
    - 0000000/011 sltu 00100
    - 0000000/100 xor 00101
    - 0000000/101 srl 00110
    - 0100000/101 sra 00111
    - 0000000/110 or 01000
    - 0000000/111 and 01001
    - Any other f7 is illegal.
  - OP-IMM 0010011, use_imm=1, reg_write=1, imm = sign-extended instr[31:20]. Mapping of f3 to alu_ctr:
    - 000 addi 01010
    - 010 slti 01011
    - 011 sltiu 01100
    - 100 xori 01101
    - 110 ori 01110
    - 111 andi 01111
    - 001 slli 10001, requires f7=0000000
    - 101 srli 10010 when f7=0000000; srai 10011 when f7=0100000
    - For shifts, imm[4:0] = shamt.
  - LUI 0110111:
    - alu_ctr=00000, use_imm=1, reg_write=1.
    - rs1_addr forced to 0; imm = {instr[31:12], 12'b0}.
  - All fields: rd_addr = instr[11:7], rs1_addr = instr[19:15], rs2_addr = instr[24:20], except the LUI rs1_addr override above.
  - Codes 10000 and 10100–11111 are never emitted.
- Illegal:
  - Any other opcode or malformed f7 gives illegal=1, reg_write=0, alu_ctr=00000.
  - The entry is still delivered and counted.
- rd=x0:
  - Decoded normally with reg_write=1; the register file ignores writes to x0.

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI;
  - funct7 constants F7_BASE, F7_ALT;
  - ALU control constants ALU_ADD … ALU_SRAI, with the values above, also used by the ALU.
- One combinational sub-module rv32i_decoder (instr → decoded fields).
- The top level holds only the pipeline register, handshake, flush and counter.

Test Plan:
- ADD x3,x1,x2 = 0x002081B3 accepted → next cycle out_valid=1, alu_ctr=00000, rd=3, rs1=1, rs2=2, use_imm=0, reg_write=1, illegal=0.
- SUB x5,x6,x7 = 0x407302B3, then ADDI x1,x0,-1 = 0xFFF00093 back-to-back with out_ready=1:
  - first: alu_ctr=00001;
  - second: alu_ctr=01010, imm=0xFFFFFFFF, use_imm=1;
  - dec_count=2.
- SRAI x2,x2,3 = 0x40315113 → alu_ctr=10011, imm[4:0]=3. LUI x4,0x12345 = 0x12345237 → alu_ctr=00000, imm=0x12345000, rs1=0.
- Instruction 0x00000000 and 0x80000033 (OP with bad f7) → illegal=1, reg_write=0, both delivered.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs stable. Release → next instruction appears the following cycle, none lost or duplicated.
- Assert flush while out_valid=1, out_ready=1, in_valid=1 → next cycle out_valid=0, dec_count unchanged. Also: rst mid-stream → all outputs 0 the next cycle.
